// File: rtl/reg_dump_reader.sv
// Walks a register-file debug port from first_addr to last_addr (wrapping) and streams each index/value pair out.
// Latency: the first word is valid two cycles after the start cycle, and each later word follows two cycles after the previous handshake.
// Backpressure: a presented word holds until out_valid&&out_ready. Define REG_DUMP_CHECKSUM_EN to add an XOR checksum of the dumped words.
module reg_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] lastAddr;
    logic              handshake;
    logic              acceptStart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        busy        = 1'b1;
        done        = 1'b0;
        handshake   = 1'b0;
        acceptStart = 1'b0;
        case (state)
            IDLE: begin
                busy        = 1'b0;
                acceptStart = start;
                if (start) begin
                    nextState = READ;
                end
            end
            READ: begin
                nextState = HOLD;
            end
            HOLD: begin
                handshake = out_valid && out_ready;
                if (handshake) begin
                    nextState = (out_addr == lastAddr) ? DONE : READ;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // rf_addr only moves on the edge leaving IDLE (load) or HOLD (advance), so it is stable for the whole READ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_addr   <= '0;
            lastAddr  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acceptStart) begin
                        rf_addr  <= first_addr;
                        lastAddr <= last_addr;
                    end
                end
                READ: begin
                    out_data  <= rf_data;
                    out_addr  <= rf_addr;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (out_addr != lastAddr) begin
                            rf_addr <= rf_addr + ADDR_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (acceptStart) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule
